fetch_arbiter: RTL and testbench
================================

// Module: fetch_arbiter
// PURPOSE
//   Shares one instruction-memory read port between NUM_REQ per-warp fetchers.
//   - Round-robin arbitration; one outstanding read at a time.
//   - Each fetcher sees the same valid/address -> ready/data handshake a private port would give.
//   - Sits between the fetcher instances in the compute core and the instruction memory controller.
// PARAMETERS
//   NUM_REQ   4   number of fetcher requesters (>=2)
//   IDX_W     $clog2(NUM_REQ)   width of grant index (derived, do not override)
// PORTS
//   clk                     in   1                    core clock, rising edge
//   reset                   in   1                    asynchronous, active-low (0 = in reset)
//   req_valid               in   NUM_REQ              per-fetcher read request, held until its req_ready
//   req_address             in   NUM_REQ x instruction_memory_address_t   per-fetcher read address
//   req_ready               out  NUM_REQ              one-cycle pulse to the serviced fetcher
//   req_data                out  instruction_t        returned instruction, broadcast to all, valid with req_ready
//   mem_read_valid          out  1                    request to instruction memory
//   mem_read_address        out  instruction_memory_address_t   address to instruction memory
//   mem_read_ready          in   1                    memory response strobe
//   mem_read_data           in   instruction_t        memory response data, valid with mem_read_ready
//   grant_count (macro)     out  NUM_REQ x 32         per-requester serviced-read counters
// BEHAVIOUR
//   Reset values (asynchronous on reset==0):
//     state=IDLE, rr_ptr=0, req_ready=0, req_data=0, mem_read_valid=0, mem_read_address=0.
//     Any in-flight read is abandoned; memory must tolerate a dropped request.
//   FSM states: IDLE -> BUSY -> RESPOND -> IDLE.
//   IDLE:
//     - If any req_valid: grant the first set bit scanning rr_ptr, rr_ptr+1, ... (mod NUM_REQ).
//     - Latch grant index and req_address[grant]; go to BUSY.
//     - mem_read_ready in IDLE is ignored.
//   BUSY:
//     - mem_read_valid=1; mem_read_address = latched address (stable all of BUSY).
//     - On mem_read_ready: register req_data=mem_read_data, req_ready[grant]=1, rr_ptr=grant+1 (wraps to 0 at NUM_REQ); go to RESPOND.
//   RESPOND:
//     - req_ready one-hot for exactly this cycle; mem_read_valid=0; go to IDLE.
//     - req_data holds its value until the next RESPOND.
//   Latency:
//     - Request seen in IDLE at cycle 0 -> mem_read_valid from cycle 1.
//     - mem_read_ready at cycle k -> req_ready at cycle k+1.
//     - Back-to-back throughput: one read per (mem latency + 3) cycles.
//   Requester rule: drop req_valid in the cycle after req_ready; a re-request needs a new arbitration.
//   Withdrawal: req_valid dropped while granted does not abort; the read completes and req_ready still pulses.
//   Simultaneous requests: only one grant per IDLE cycle; losers keep valid asserted and are not starved.
//     - Worst-case wait: NUM_REQ-1 transactions.
//   req_address of non-granted requesters is never sampled; address changes after the IDLE latch are ignored.
//   At most one req_ready bit set in any cycle; mem_read_valid never asserted in IDLE or RESPOND.
// CONFIGURATION
//   FETCH_ARBITER_PERF_EN defined:
//     - grant_count port present; counter[i] +1 in each RESPOND cycle where grant==i.
//     - Saturates at 32'hFFFF_FFFF; cleared to 0 by reset.
//   Undefined: port and counters absent; all other behaviour identical.
// TESTING
//   1. Hold reset=0, drive req_valid=4'hF, mem_read_ready=1 -> all outputs 0 for the whole of reset.
//   2. req_valid=4'b0100, req_address[2]=0x40, mem_read_ready 3 cycles after mem_read_valid with data 32'hDEADBEEF
//      -> mem_read_address=0x40; req_ready=4'b0100 for one cycle; req_data=32'hDEADBEEF.
//   3. req_valid=4'hF from reset, memory ready 1 cycle after request -> grant order 0,1,2,3,0.
//      Each requester drops valid after its ready and re-raises it.
//   4. Previous grant=1, then req_valid=4'b1010 -> requester 3 serviced before 1.
//   5. Assert reset=0 mid-BUSY -> mem_read_valid=0 immediately and no req_ready pulse.
//      After release, requester 0 request serviced normally.
//   6. FETCH_ARBITER_PERF_EN: 5 reads by req0, 2 by req3 -> grant_count = {2,0,0,5} (index 3..0).
//      Reset clears all counters to 0.

Source files
------------

// File: rtl/fetch_arbiter.sv
// Round-robin arbiter sharing one instruction-memory read port among NUM_REQ fetchers.
// Optional per-requester serviced-read counters when FETCH_ARBITER_PERF_EN is defined.
module fetch_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_address,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [DATA_W-1:0]               req_data,
  output logic                            mem_read_valid,
  output logic [ADDR_W-1:0]               mem_read_address,
  input  logic                            mem_read_ready,
  input  logic [DATA_W-1:0]               mem_read_data
`ifdef FETCH_ARBITER_PERF_EN
  ,
  output logic [NUM_REQ-1:0][31:0]        grant_count
`endif
);

  // state   | meaning
  // IDLE    | waiting for any req_valid; picks the next requester round-robin
  // BUSY    | read presented to memory, waiting for mem_read_ready
  // RESPOND | one-cycle req_ready pulse to the granted requester
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   grant;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  int                 scan_idx;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!pick_found && req_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(scan_idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_found) state_nxt = BUSY;
      BUSY:    if (mem_read_ready) state_nxt = RESPOND;
      RESPOND: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      grant            <= '0;
      rr_ptr           <= '0;
      mem_read_address <= '0;
      req_data         <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_found) begin
        grant            <= pick_idx;
        mem_read_address <= req_address[pick_idx];
      end
      if (state == BUSY && mem_read_ready) begin
        req_data <= mem_read_data;
        rr_ptr   <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + IDX_W'(1);
      end
    end
  end

  // Derived from the registered state so reset clears them without waiting for a clock.
  assign mem_read_valid = (state == BUSY);
  assign req_ready      = (state == RESPOND) ? (NUM_REQ'(1) << grant) : '0;

`ifdef FETCH_ARBITER_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_count <= '0;
    end else if (state == RESPOND && grant_count[grant] != 32'hFFFF_FFFF) begin
      grant_count[grant] <= grant_count[grant] + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_arbiter.sv
// Scoreboard bench for fetch_arbiter: directed reads, a behavioural memory and a decoupled monitor.
module tb_fetch_arbiter;

  logic             clk;
  logic             rst_n;
  logic [3:0]       req_valid;
  logic [3:0][15:0] req_address;
  logic [3:0]       req_ready;
  logic [31:0]      req_data;
  logic             mem_read_valid;
  logic [15:0]      mem_read_address;
  logic             mem_read_ready;
  logic [31:0]      mem_read_data;
`ifdef FETCH_ARBITER_PERF_EN
  logic [3:0][31:0] grant_count;
`endif

  fetch_arbiter #(.NUM_REQ(4), .ADDR_W(16), .DATA_W(32)) dut (
    .clk              (clk),
    .reset            (rst_n),
    .req_valid        (req_valid),
    .req_address      (req_address),
    .req_ready        (req_ready),
    .req_data         (req_data),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data)
`ifdef FETCH_ARBITER_PERF_EN
    ,
    .grant_count      (grant_count)
`endif
  );

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic [15:0] addr;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          mem_en = 0;
  int          mem_lat = 1;
  int          wait_cnt = 0;
  logic [15:0] last_addr = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [15:0] a);
    return (a == 16'h0040) ? 32'hDEADBEEF : {16'hF00D, a};
  endfunction

  // Memory model: answers mem_lat cycles after it first sees mem_read_valid.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_en) begin
        mem_read_ready = 1'b0;
        if (mem_read_valid) begin
          if (wait_cnt >= mem_lat) begin
            mem_read_ready = 1'b1;
            mem_read_data  = mem_fn(mem_read_address);
            last_addr      = mem_read_address;
            wait_cnt       = 0;
          end else begin
            wait_cnt++;
          end
        end else begin
          wait_cnt = 0;
        end
      end
    end
  end

  // Monitor: every req_ready pulse must match the head of the scoreboard.
  initial begin
    exp_t       e;
    logic [3:0] oh;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && req_ready !== 4'b0000) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_ready got=%b expected=none", req_ready);
        end else begin
          e  = sb.pop_front();
          oh = 4'b0001 << e.idx;
          if (req_ready !== oh || req_data !== e.data || last_addr !== e.addr) begin
            n_err++;
            $display("FAIL sb_read got ready=%b data=%h addr=%h expected ready=%b data=%h addr=%h",
                     req_ready, req_data, last_addr, oh, e.data, e.addr);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic expect_rd(input int idx);
    exp_t e;
    e.idx  = idx;
    e.addr = req_address[idx];
    e.data = (idx == 2) ? 32'hDEADBEEF : {16'hF00D, req_address[idx]};
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_mrv(input string nm);
    int b = 0;
    while (mem_read_valid !== 1'b1 && b < 50) begin
      @(negedge clk);
      b++;
    end
    if (mem_read_valid !== 1'b1) check({nm, "_timeout"}, 64'd0, 64'd1);
  endtask

  // Requesters hold valid until ready, drop it across the next IDLE, then re-request.
  task automatic run_reqs(input int c0, input int c1, input int c2, input int c3);
    int rem[4];
    int hold[4];
    int budget = 0;
    rem = '{c0, c1, c2, c3};
    for (int i = 0; i < 4; i++) begin
      hold[i]      = 0;
      req_valid[i] = (rem[i] > 0);
    end
    while ((rem[0] + rem[1] + rem[2] + rem[3]) > 0 && budget < 2000) begin
      @(negedge clk);
      budget++;
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          rem[i]--;
          req_valid[i] = 1'b0;
          hold[i]      = 2;
        end else if (!req_valid[i] && rem[i] > 0) begin
          if (hold[i] > 0) hold[i]--;
          if (hold[i] == 0) req_valid[i] = 1'b1;
        end
      end
    end
    if (budget >= 2000) check("run_reqs_timeout", 64'd0, 64'd1);
    req_valid = '0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    req_address[0] = 16'h0010;
    req_address[1] = 16'h0024;
    req_address[2] = 16'h0040;
    req_address[3] = 16'h003C;
    mem_read_data  = '0;

    // Reset held with every input active: outputs stay cleared.
    rst_n          = 1'b0;
    req_valid      = 4'hF;
    mem_read_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("reset_outputs", {req_ready, req_data, mem_read_valid, mem_read_address},
            64'd0);
    end
    req_valid      = '0;
    mem_read_ready = 1'b0;
    mem_en         = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single read by requester 2 with three-cycle memory latency.
    mem_lat = 3;
    expect_rd(2);
    req_valid[2] = 1'b1;
    wait_mrv("t2_mrv");
    check("t2_mem_addr", mem_read_address, 64'h40);
    req_address[2] = 16'h0077;
    @(negedge clk);
    check("t2_addr_stable", mem_read_address, 64'h40);
    begin
      int b = 0;
      while (req_ready[2] !== 1'b1 && b < 50) begin
        @(negedge clk);
        b++;
      end
    end
    req_valid[2] = 1'b0;
    @(negedge clk);
    check("t2_ready_one_cycle", req_ready, 64'h0);
    check("t2_data_held", req_data, 64'hDEADBEEF);
    req_address[2] = 16'h0040;
    @(negedge clk);

    // All requesting from reset: order 0,1,2,3,0.
    mem_lat = 1;
    do_reset();
    expect_rd(0); expect_rd(1); expect_rd(2); expect_rd(3); expect_rd(0);
    run_reqs(2, 1, 1, 1);

    // Last grant 1, then 1 and 3 together: 3 before 1.
    expect_rd(1);
    run_reqs(0, 1, 0, 0);
    expect_rd(3); expect_rd(1);
    run_reqs(0, 1, 0, 1);

    // Reset in the middle of BUSY aborts the read.
    mem_lat = 5;
    req_valid[2] = 1'b1;
    wait_mrv("t5_mrv");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("t5_abort_now", {mem_read_valid, req_ready}, 64'h0);
    req_valid[2] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t5_abort_hold", {mem_read_valid, req_ready}, 64'h0);
    end
    rst_n   = 1'b1;
    mem_lat = 1;
    @(negedge clk);
    expect_rd(0);
    run_reqs(1, 0, 0, 0);

`ifdef FETCH_ARBITER_PERF_EN
    do_reset();
    check("perf_after_reset", grant_count[0] | grant_count[3], 64'h0);
    repeat (5) expect_rd(0);
    run_reqs(5, 0, 0, 0);
    repeat (2) expect_rd(3);
    run_reqs(0, 0, 0, 2);
    check("perf_count_lo", {grant_count[1], grant_count[0]}, {32'd0, 32'd5});
    check("perf_count_hi", {grant_count[3], grant_count[2]}, {32'd2, 32'd0});
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("perf_cleared", {grant_count[3], grant_count[0]}, 64'h0);
    rst_n = 1'b1;
`endif

    repeat (5) @(negedge clk);
    check("sb_drained", sb.size(), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
